// File: rtl/nexys_starship_monster_sched_if.sv
// Handshake bundle between the monster scheduler and the game logic around it.
// The slave side is the scheduler; the master side drives tick/play/restart/shoot.
interface nexys_starship_monster_sched_if;
  logic       tick;
  logic       play_flag;
  logic       restart;
  logic [3:0] shoot;
  logic [3:0] spawn;
  logic [3:0] monster_present;
  logic [7:0] score;
  logic       game_over;
  logic       q_Idle;
  logic       q_Run;
  logic       q_Over;

  modport master (
    output tick, play_flag, restart, shoot,
    input  spawn, monster_present, score, game_over, q_Idle, q_Run, q_Over
  );

  modport slave (
    input  tick, play_flag, restart, shoot,
    output spawn, monster_present, score, game_over, q_Idle, q_Run, q_Over
  );
endinterface

// File: rtl/nexys_starship_monster_sched.sv
// Game-level scheduler: IDLE/RUN/OVER FSM, LFSR-driven spawning into the four
// monster slots, per-slot kill deadlines and a saturating kill score.
module nexys_starship_monster_sched #(
  parameter int          SPAWN_INTERVAL = 16,
  parameter int          FIRE_TIMEOUT   = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  nexys_starship_monster_sched_if.slave        bus
);

  localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int TW = $clog2(FIRE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_INTERVAL - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(FIRE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_OVER = 3'b100
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [15:0]          lfsr;
  logic [CW-1:0]        interval_cnt;
  logic [CW-1:0]        interval_cnt_nxt;
  logic [3:0][TW-1:0]   timer;
  logic [3:0][TW-1:0]   timer_nxt;
  logic [3:0]           present;
  logic [3:0]           present_nxt;
  logic [3:0]           spawn_r;
  logic [3:0]           spawn_nxt;
  logic [3:0]           kills;
  logic [7:0]           score;
  logic [7:0]           score_nxt;
  logic                 attempt;
  logic                 expire;

  // First empty slot searching c, c+1, c+2, c+3 (mod 4); zero when all full.
  function automatic logic [3:0] pick_slot(input logic [3:0] occ, input logic [1:0] c);
    logic [1:0] s;
    logic [3:0] pick;
    pick = '0;
    for (int k = 3; k >= 0; k--) begin
      s = c + 2'(k);
      if (!occ[s]) pick = 4'b0001 << s;
    end
    return pick;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] s, input logic [3:0] k);
    logic [8:0] sum;
    sum = {1'b0, s} + 9'($countones(k));
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.play_flag) state_nxt = S_RUN;
      S_RUN:   if (expire)        state_nxt = S_OVER;
      S_OVER:  if (bus.restart)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.q_Idle          = (state == S_IDLE);
    bus.q_Run           = (state == S_RUN);
    bus.q_Over          = (state == S_OVER);
    bus.game_over       = (state == S_OVER);
    bus.spawn           = spawn_r;
    bus.monster_present = present;
    bus.score           = score;
  end

  // Only slots occupied at the start of the cycle can be killed or time out,
  // so a slot being shot is never treated as empty by the spawn search.
  always_comb begin
    kills            = bus.shoot & present;
    expire           = 1'b0;
    attempt          = 1'b0;
    interval_cnt_nxt = interval_cnt;
    timer_nxt        = timer;
    present_nxt      = present;
    score_nxt        = score;
    spawn_nxt        = '0;
    case (state)
      S_IDLE: begin
        interval_cnt_nxt = '0;
        timer_nxt        = '0;
        present_nxt      = '0;
        score_nxt        = '0;
      end
      S_RUN: begin
        if (bus.tick) begin
          if (interval_cnt == CNT_LAST) begin
            interval_cnt_nxt = '0;
            attempt          = 1'b1;
          end else begin
            interval_cnt_nxt = interval_cnt + 1'b1;
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (kills[i]) begin
            timer_nxt[i] = '0;
          end else if (present[i] && bus.tick) begin
            if (timer[i] == TW'(1)) expire = 1'b1;
            if (timer[i] != '0) timer_nxt[i] = timer[i] - 1'b1;
          end
        end
        present_nxt = present & ~kills;
        score_nxt   = sat_add(score, kills);
        // The game is lost this cycle: no new monster appears.
        if (attempt && !expire) begin
          spawn_nxt   = pick_slot(present, lfsr[1:0]);
          present_nxt = present_nxt | spawn_nxt;
          for (int i = 0; i < 4; i++) begin
            if (spawn_nxt[i]) timer_nxt[i] = TMR_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  // LFSR free-runs in every state so time spent idle feeds slot selection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr         <= LFSR_SEED;
      interval_cnt <= '0;
      timer        <= '0;
      present      <= '0;
      score        <= '0;
      spawn_r      <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      interval_cnt <= interval_cnt_nxt;
      timer        <= timer_nxt;
      present      <= present_nxt;
      score        <= score_nxt;
      spawn_r      <= spawn_nxt;
    end
  end

endmodule
